// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width constant and opcode encoding for the 4-bit ALU
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_INC = 3'd6,
    OP_DEC = 3'd7
  } opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_4bit_comb.sv
// rtl/alu_4bit_comb.sv - combinational operation and flag generation
module alu_4bit_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH:0]   ONE     = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  // One extra bit on every arithmetic path so the wrapped-out bit lands on carry/borrow.
  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;
  assign inc   = a_ext + ONE;
  assign dec   = a_ext - ONE;

  always_comb begin
    result         = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (opcode_t'(sel))
      OP_ADD: begin
        {flags.carry, result} = sum;
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        {flags.carry, result} = diff;
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_INC: begin
        {flags.carry, result} = inc;
        flags.overflow = (a == MAX_POS);
      end
      OP_DEC: begin
        {flags.carry, result} = dec;
        flags.overflow = (a == MIN_NEG);
      end
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - registered ALU with one-cycle valid-qualified issue
module alu_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] comb_result;
  alu_flags_t       comb_flags;

  alu_4bit_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a      (A),
    .b      (B),
    .sel    (sel),
    .result (comb_result),
    .flags  (comb_flags)
  );

  // Reset wins over an op issued in the same cycle; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= comb_result;
        carry    <= comb_flags.carry;
        zero     <= comb_flags.zero;
        overflow <= comb_flags.overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// tb/tb_alu_4bit.sv - directed self-checking bench for alu_4bit
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] sel;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  alu_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Observed/expected packing: {result, carry, zero, overflow, out_valid}
  function automatic logic [7:0] pack(input logic [3:0] r, input logic c, input logic z,
                                      input logic o, input logic v);
    return {r, c, z, o, v};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{r,c,z,o,v}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] s);
    rst = r; in_valid = v; A = a; B = b; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] s, input logic [3:0] er, input logic ec,
                          input logic ez, input logic eo);
    step(1'b0, 1'b1, a, b, s);
    check_eq(tag, pack(result, carry, zero, overflow, out_valid), pack(er, ec, ez, eo, 1'b1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0;

    // Reset held two cycles with a live op that must be ignored
    step(1'b1, 1'b1, 4'b0111, 4'b0001, 3'b000);
    check_eq("reset_c1", pack(result, carry, zero, overflow, out_valid), pack(4'b0000, 0, 1, 0, 0));
    step(1'b1, 1'b1, 4'b1111, 4'b0001, 3'b000);
    check_eq("reset_c2", pack(result, carry, zero, overflow, out_valid), pack(4'b0000, 0, 1, 0, 0));

    // Opcode sweep, A=0101 B=0011, back-to-back
    op_check("sweep_add", 4'b0101, 4'b0011, 3'b000, 4'b1000, 0, 0, 1);
    op_check("sweep_sub", 4'b0101, 4'b0011, 3'b001, 4'b0010, 0, 0, 0);
    op_check("sweep_and", 4'b0101, 4'b0011, 3'b010, 4'b0001, 0, 0, 0);
    op_check("sweep_or",  4'b0101, 4'b0011, 3'b011, 4'b0111, 0, 0, 0);
    op_check("sweep_xor", 4'b0101, 4'b0011, 3'b100, 4'b0110, 0, 0, 0);
    op_check("sweep_not", 4'b0101, 4'b0011, 3'b101, 4'b1010, 0, 0, 0);
    op_check("sweep_inc", 4'b0101, 4'b0011, 3'b110, 4'b0110, 0, 0, 0);
    op_check("sweep_dec", 4'b0101, 4'b0011, 3'b111, 4'b0100, 0, 0, 0);

    // Carry/borrow boundaries landing on zero
    op_check("add_wrap",  4'b1111, 4'b0001, 3'b000, 4'b0000, 1, 1, 0);
    op_check("sub_equal", 4'b0011, 4'b0011, 3'b001, 4'b0000, 0, 1, 0);
    op_check("inc_wrap",  4'b1111, 4'b0000, 3'b110, 4'b0000, 1, 1, 0);
    op_check("dec_one",   4'b0001, 4'b0000, 3'b111, 4'b0000, 0, 1, 0);
    op_check("xor_same",  4'b1010, 4'b1010, 3'b100, 4'b0000, 0, 1, 0);

    // Borrow/overflow boundaries
    op_check("sub_borrow", 4'b0010, 4'b0101, 3'b001, 4'b1101, 1, 0, 0);
    op_check("dec_zero",   4'b0000, 4'b0000, 3'b111, 4'b1111, 1, 0, 0);
    op_check("dec_minneg", 4'b1000, 4'b0000, 3'b111, 4'b0111, 0, 0, 1);
    op_check("sub_ovf",    4'b1000, 4'b0001, 3'b001, 4'b0111, 0, 0, 1);
    op_check("inc_maxpos", 4'b0111, 4'b0000, 3'b110, 4'b1000, 0, 0, 1);
    op_check("add_negovf", 4'b1000, 4'b1000, 3'b000, 4'b0000, 1, 1, 1);

    // Hold while idle with wiggling inputs
    op_check("hold_load", 4'b0101, 4'b0011, 3'b000, 4'b1000, 0, 0, 1);
    step(1'b0, 1'b0, 4'b1111, 4'b1111, 3'b001);
    check_eq("hold_c1", pack(result, carry, zero, overflow, out_valid), pack(4'b1000, 0, 0, 1, 0));
    step(1'b0, 1'b0, 4'b0000, 4'b0001, 3'b111);
    check_eq("hold_c2", pack(result, carry, zero, overflow, out_valid), pack(4'b1000, 0, 0, 1, 0));
    step(1'b0, 1'b0, 4'b1010, 4'b0101, 3'b100);
    check_eq("hold_c3", pack(result, carry, zero, overflow, out_valid), pack(4'b1000, 0, 0, 1, 0));

    // Mid-stream reset on the third of four back-to-back ops
    op_check("mid_op1", 4'b1100, 4'b1010, 3'b010, 4'b1000, 0, 0, 0);
    op_check("mid_op2", 4'b0001, 4'b0010, 3'b011, 4'b0011, 0, 0, 0);
    step(1'b1, 1'b1, 4'b0111, 4'b0001, 3'b000);
    check_eq("mid_rst", pack(result, carry, zero, overflow, out_valid), pack(4'b0000, 0, 1, 0, 0));
    op_check("mid_op4", 4'b0111, 4'b0010, 3'b001, 4'b0101, 0, 0, 0);

    step(1'b0, 1'b0, 4'b0000, 4'b0000, 3'b000);
    check_eq("final_idle", pack(result, carry, zero, overflow, out_valid), pack(4'b0101, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
Name: alu_4bit

Overview:
Registered 4-bit arithmetic/logic unit that executes one of eight operations on operands A and B, selected by a 3-bit opcode. It produces a 4-bit result, a carry/borrow bit and zero/overflow status flags.
Outputs are captured one clock after a valid input. It is used as a small datapath execution element under a simple valid-qualified issue interface.

Parameters:
- WIDTH, 4, operand/result width; all values and tests below assume 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid this cycle
- A  input  WIDTH  operand A (unsigned, or two's complement for overflow)
- B  input  WIDTH  operand B
- sel  input  3  opcode
- result  output  WIDTH  registered operation result
- carry  output  1  registered carry-out / borrow
- zero  output  1  registered: result == 0
- overflow  output  1  registered signed overflow
- out_valid  output  1  result/flags valid (1-cycle pulse per accepted input)

Behaviour:
- Opcode map (sel):
  - 000 ADD: {carry,result} = A + B (5-bit sum)
  - 001 SUB: {carry,result} = {0,A} - {0,B} mod 2^5; carry=1 means borrow (A < B)
  - 010 AND: result = A & B
  - 011 OR: result = A | B
  - 100 XOR: result = A ^ B
  - 101 NOT: result = ~A (B ignored)
  - 110 INC: {carry,result} = A + 1; carry=1 only when A=1111
  - 111 DEC: {carry,result} = {0,A} - 1 mod 2^5; carry=1 only when A=0000
- Logic ops (010–101): carry=0, overflow=0.
- Overflow (signed two's complement):
  - ADD: A[3]==B[3] && result[3]!=A[3]
  - SUB: A[3]!=B[3] && result[3]!=A[3]
  - INC: A=0111
  - DEC: A=1000
- zero = (result == 0) for every opcode.
- Latency and valid:
  - Exactly 1 cycle: inputs sampled at edge N with in_valid=1; result/flags visible after that edge, with out_valid=1 for that cycle.
  - in_valid=0 at an edge: result/carry/zero/overflow hold their previous values; out_valid=0.
  - Back-to-back in_valid accepted every cycle (no backpressure, full throughput).
- Reset: rst=1 at an edge forces result=0, carry=0, overflow=0, out_valid=0, zero=1. Reset has priority over in_valid; an operation issued in the same cycle as reset is discarded.
- Arithmetic wraps modulo 2^WIDTH, with the lost bit reported on carry. No X propagation: all opcodes are defined, so no default/illegal case.

Decomposition:
- Package alu_pkg: WIDTH default constant; opcode enum OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_INC=6, OP_DEC=7.
- One natural sub-module, alu_4bit_comb: purely combinational op/flag generation. The top module adds the output registers, valid pipeline and reset.

Test Plan:
- Reset: rst=1 for 2 cycles -> result=0000, carry=0, zero=1, overflow=0, out_valid=0. Issuing in_valid during reset has no effect.
- A=0101, B=0011, sweep sel 000..111 (one per cycle, in_valid=1) -> results next cycle, each with out_valid=1:
  - ADD: 1000, c0, ovf1
  - SUB: 0010, c0
  - AND: 0001
  - OR: 0111
  - XOR: 0110
  - NOT: 1010
  - INC: 0110
  - DEC: 0100
- Carry/borrow boundaries -> each reports zero=1:
  - ADD 1111+0001 -> 0000, c1
  - SUB 0011-0011 -> 0000, c0
  - INC 1111 -> 0000, c1
  - DEC 0001 -> 0000, c0
  - XOR A=B -> 0000, c0
- Borrow/overflow boundaries:
  - SUB 0010-0101 -> 1101, c1, ovf0
  - DEC 0000 -> 1111, c1
  - DEC 1000 -> 0111, ovf1
  - SUB 1000-0001 -> 0111, ovf1, c0
- Hold behaviour: after ADD 0101+0011, drop in_valid and change A/B/sel for 3 cycles -> outputs stay 1000/c0, out_valid=0.
- Mid-stream reset: 4 back-to-back valid ops with rst asserted on the 3rd issue cycle -> the 3rd op is discarded, outputs take reset values, and the 4th op appears normally one cycle later.
